// File: rtl/alu_seq_ctrl_pkg.sv
// Shared codes for the ALU multiply/divide sequencer:
// ALU control words, FSM states and operation selects.
package alu_seq_ctrl_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_X         = 6'b001100;
  localparam alu_ctrl_t ALU_X_PLUS_Y  = 6'b000010;
  localparam alu_ctrl_t ALU_X_MINUS_Y = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic OP_MUL  = 1'b0;
  localparam logic OP_DIVU = 1'b1;

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// Hack ALU: optional zero/negate on each operand,
// add or AND, optional negate of the result.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_zx,
  input  logic             i_nx,
  input  logic             i_zy,
  input  logic             i_ny,
  input  logic             i_f,
  input  logic             i_no,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zr,
  output logic             o_ng
);

  logic [WIDTH-1:0] w_x0;
  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_y0;
  logic [WIDTH-1:0] w_y1;
  logic [WIDTH-1:0] w_f;

  assign w_x0  = i_zx ? '0 : i_x;
  assign w_x1  = i_nx ? ~w_x0 : w_x0;
  assign w_y0  = i_zy ? '0 : i_y;
  assign w_y1  = i_ny ? ~w_y0 : w_y0;
  assign w_f   = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
  assign o_out = i_no ? ~w_f : w_f;
  assign o_zr  = (o_out == '0);
  assign o_ng  = o_out[WIDTH-1];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle unsigned multiply / restoring divide,
// one Hack ALU operation per cycle, start/busy/done.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_e r_state;
  state_e w_next;

  // r_acc doubles as rem, r_mcand as quo
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [3:0]       r_count;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;

  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH-1:0] w_quo_sh;
  logic             w_carry;
  logic             w_ge;
  logic             w_dz;
  logic             w_last;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  alu_ctrl_t        w_ctrl;
  logic [WIDTH-1:0] w_alu;
  logic             w_zr;
  logic             w_ng;
  logic [1:0]       w_unused_flags;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_mcand_nx;

  assign w_rem_sh = {r_acc[WIDTH-2:0], r_mcand[WIDTH-1]};
  assign w_quo_sh = {r_mcand[WIDTH-2:0], 1'b0};
  assign w_carry  = r_acc[WIDTH-1];
  assign w_ge     = w_carry | (w_rem_sh >= r_b);
  assign w_dz     = (r_op == OP_DIVU) && (r_b == '0);
  assign w_last   = (r_count == 4'hF);

  always_comb begin
    w_x    = r_acc;
    w_y    = r_mcand;
    w_ctrl = ALU_X;
    if (r_op == OP_DIVU) begin
      w_x = w_rem_sh;
      w_y = r_b;
    end
    if (r_state == S_RUN) begin
      w_ctrl = (r_op == OP_DIVU) ? ALU_X_MINUS_Y : ALU_X_PLUS_Y;
    end
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_x  (w_x),
    .i_y  (w_y),
    .i_zx (w_ctrl.zx),
    .i_nx (w_ctrl.nx),
    .i_zy (w_ctrl.zy),
    .i_ny (w_ctrl.ny),
    .i_f  (w_ctrl.f),
    .i_no (w_ctrl.no),
    .o_out(w_alu),
    .o_zr (w_zr),
    .o_ng (w_ng)
  );

  assign w_unused_flags = {w_zr, w_ng};

  always_comb begin
    w_acc_nx   = r_acc;
    w_mcand_nx = r_mcand;
    if (r_op == OP_DIVU) begin
      w_acc_nx   = w_ge ? w_alu : w_rem_sh;
      w_mcand_nx = {w_quo_sh[WIDTH-1:1], w_ge};
    end else begin
      w_acc_nx   = r_mplier[0] ? w_alu : r_acc;
      w_mcand_nx = w_quo_sh;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_dz || w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_b         <= '0;
      r_op        <= OP_MUL;
      r_count     <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_mcand    <= a;
            r_mplier   <= b;
            r_b        <= b;
            r_op       <= op;
            r_count    <= '0;
            r_div_zero <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_dz) begin
            r_result    <= '1;
            r_remainder <= r_mcand;
            r_div_zero  <= 1'b1;
          end else begin
            r_acc    <= w_acc_nx;
            r_mcand  <= w_mcand_nx;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 4'd1;
            if (w_last) begin
              r_result    <= (r_op == OP_DIVU) ? w_mcand_nx : w_acc_nx;
              r_remainder <= (r_op == OP_DIVU) ? w_acc_nx : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: vector table plus
// ignored-start and mid-run reset sequences.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] remainder;
  logic        div_zero;

  int n_cmp;
  int n_bad;

  alu_seq_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] rem;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue start at E0, scramble operands, count edges to done.
  task automatic run_op(input logic o, input logic [15:0] xa,
                        input logic [15:0] xb, output int lat);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = xa;
    b     = xb;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    a     = 16'hA5A5;
    b     = 16'h0000;
    lat   = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{"mul3x5",     1'b0, 16'd3,    16'd5,    16'd15,   16'd0,    1'b0, 16};
    vecs[1] = '{"mul300",     1'b0, 16'd300,  16'd300,  16'h5F90, 16'd0,    1'b0, 16};
    vecs[2] = '{"mulffff",    1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'd0,    1'b0, 16};
    vecs[3] = '{"mul0",       1'b0, 16'd0,    16'h1234, 16'd0,    16'd0,    1'b0, 16};
    vecs[4] = '{"div100_7",   1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 16};
    vecs[5] = '{"divcarry",   1'b1, 16'hFFFF, 16'hFFFE, 16'd1,    16'd1,    1'b0, 16};
    vecs[6] = '{"div5_9",     1'b1, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0, 16};
    vecs[7] = '{"divzero",    1'b1, 16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[8] = '{"mul2x2",     1'b0, 16'd2,    16'd2,    16'd4,    16'd0,    1'b0, 16};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      run_op(vecs[k].op, vecs[k].a, vecs[k].b, lat);
      chk({vecs[k].name, "_lat"}, lat, vecs[k].lat);
      chk({vecs[k].name, "_busy"}, busy, 1);
      chk({vecs[k].name, "_res"}, result, vecs[k].res);
      chk({vecs[k].name, "_rem"}, remainder, vecs[k].rem);
      chk({vecs[k].name, "_dz"}, div_zero, vecs[k].dz);
      @(posedge clk);
      #1;
      chk({vecs[k].name, "_idle"}, {busy, done}, 0);
      chk({vecs[k].name, "_hold"}, {result, remainder},
          {vecs[k].res, vecs[k].rem});
      chk({vecs[k].name, "_dzhold"}, div_zero, vecs[k].dz);
    end

    // start pulsed at E5 of a multiply must be ignored
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'd3;
    b     = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'd9;
    b     = 16'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("ign_lat", lat, 16);
    chk("ign_res", result, 15);
    chk("ign_rem", remainder, 0);
    chk("ign_dz", div_zero, 0);
    @(posedge clk);
    #1;
    chk("ign_idle", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("ign_noq", busy, 0);

    // reset at E8 of a divide aborts it silently
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'd100;
    b     = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abrt_out", {busy, done, result, remainder, div_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abrt_nodone", seen, 0);
    run_op(1'b1, 16'd100, 16'd7, lat);
    chk("post_lat", lat, 16);
    chk("post_res", result, 14);
    chk("post_rem", remainder, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
